display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for the speedometer's common-cathode 7-segment display. An internal one-hot ring counter walks the digit enables. A phase FSM inserts a blanking interval before each digit to prevent ghosting, and a per-digit hex decoder drives the segments. Sits between the speed-formatting logic (packed BCD/hex nibbles) and the PMOD display pins.

Parameters:
num_digits_p, 4, number of digits scanned; ring width, >=2
on_cycles_p, 1000, clk cycles a digit is lit per visit; >=1
blank_cycles_p, 16, clk cycles all digits are off before each digit; >=1

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
en_i  input  1  scan enable; sampled at frame start and digit boundaries
digits_i  input  4*num_digits_p  packed nibbles; digit k = digits_i[4k+3:4k]
dp_i  input  num_digits_p  decimal point per digit, 1 = lit
dig_sel_o  output  num_digits_p  one-hot digit enable, active-high; bit k = digit k
seg_o  output  7  segments, active-high, bit0=a .. bit6=g
dp_o  output  1  decimal point for the currently lit digit
frame_done_o  output  1  one-cycle pulse at the end of the last digit's ON phase
busy_o  output  1  high whenever state != IDLE

Behaviour:
- One clock and reset: clk_i; reset is asynchronous and active-low (rst_ni).
- Reset (rst_ni=0, async): state=IDLE; ring=0; counter=0; snapshot regs=0; all outputs 0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, BLANK, ON.
- IDLE:
  - dig_sel_o=0, seg_o=0, dp_o=0.
  - On a clk edge with en_i=1: capture digits_i/dp_i into snapshot, ring<=1 (digit 0), cnt<=0, go BLANK.
- BLANK:
  - dig_sel_o=0, seg_o=0, dp_o=0.
  - Lasts exactly blank_cycles_p cycles, then go ON with cnt<=0.
- ON:
  - dig_sel_o=ring; seg_o=decode(snapshot nibble of the ring index); dp_o=snapshot dp bit.
  - Lasts exactly on_cycles_p cycles. At the end:
    - Last digit (ring MSB set): pulse frame_done_o for the first cycle after the ON phase. If en_i=1, re-capture snapshot, ring<=1, go BLANK; else ring<=0, go IDLE.
    - Not last digit: if en_i=1, ring rotates left by one and state goes BLANK; else ring<=0, go IDLE (no frame_done_o).
- Timing:
  - Digit period = blank_cycles_p + on_cycles_p.
  - Frame = num_digits_p × digit period.
  - First dig_sel_o assertion occurs blank_cycles_p+1 cycles after the edge where en_i is sampled high in IDLE.
- Snapshot: digits_i/dp_i are sampled only at frame start. Mid-frame input changes are never visible until the next frame (no tearing).
- Invariants:
  - dig_sel_o is zero or one-hot at all times.
  - At least blank_cycles_p zero cycles separate any two different dig_sel_o values.
  - seg_o=0 and dp_o=0 whenever dig_sel_o=0.
- Decode (hex): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Counter width: $clog2(max(on_cycles_p, blank_cycles_p)+1). The counter compares against (N-1) and is never allowed to wrap.
- Reset asserted mid-ON: outputs clear immediately (async). After release the block sits in IDLE until en_i is sampled high.

Test Plan:
Use num_digits_p=4, on_cycles_p=4, blank_cycles_p=2 throughout.
1. Reset: hold rst_ni=0 5 cycles with en_i=1 -> all outputs 0. Release, en_i=1 -> dig_sel_o=0001 first appears 3 cycles after the first sampling edge.
2. Basic frame: digits_i=16'h1234, dp_i=4'b0010. Expected sequence:
   - 2 cycles blank, then 4 cycles dig_sel_o=0001 with seg_o=66 (digit 4), dp_o=0.
   - 2 blank, then 4 cycles 0010 with seg_o=4F, dp_o=1.
   - 2 blank, then 4 cycles 0100 with seg_o=5B.
   - 2 blank, then 4 cycles 1000 with seg_o=06.
   - frame_done_o pulses once; frame length = 24 cycles.
3. Snapshot: change digits_i to 16'hFFFF during digit 1's ON phase -> remainder of the frame still shows 5B/06; next frame shows 71 on all digits.
4. Disable mid-frame: drop en_i during digit 2's ON phase -> digit 2 completes its 4 cycles, then IDLE with all outputs 0 and busy_o=0; no frame_done_o pulse.
5. Decode sweep: over 4 frames, load digits_i=16'h3210, 16'h7654, 16'hBA98, 16'hFEDC -> each seg_o value matches the decode table.
6. Continuous run for 10 frames: frame_done_o pulses every 24 cycles; checker confirms dig_sel_o is never multi-hot and seg_o=0 whenever dig_sel_o=0. Assert rst_ni=0 mid-ON -> outputs clear within the same cycle.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: walks a one-hot digit enable with a
// blanking gap before every digit, decoding a per-frame snapshot of the nibbles.
module display_scan_ctrl #(
    parameter int num_digits_p   = 4,
    parameter int on_cycles_p    = 1000,
    parameter int blank_cycles_p = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic [4*num_digits_p-1:0]   digits_i,
    input  logic [num_digits_p-1:0]     dp_i,
    output logic [num_digits_p-1:0]     dig_sel_o,
    output logic [6:0]                  seg_o,
    output logic                        dp_o,
    output logic                        frame_done_o,
    output logic                        busy_o
);

    localparam int MaxCycles = (on_cycles_p > blank_cycles_p) ? on_cycles_p : blank_cycles_p;
    localparam int CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] OnLast    = CntW'(on_cycles_p - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(blank_cycles_p - 1);
    localparam logic [num_digits_p-1:0] RingFirst = num_digits_p'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [num_digits_p-1:0]     ring_q, ring_d;
    logic [CntW-1:0]             cnt_q, cnt_d;
    logic [4*num_digits_p-1:0]   snap_digits_q, snap_digits_d;
    logic [num_digits_p-1:0]     snap_dp_q, snap_dp_d;
    logic                        frame_end_q, frame_end_d;

    logic [num_digits_p-1:0]     dig_sel_q, dig_sel_d;
    logic [6:0]                  seg_q, seg_d;
    logic                        dp_q, dp_d;
    logic                        frame_done_q;
    logic                        busy_q, busy_d;

    logic [3:0]                  lit_nibble;
    logic                        lit_dp;

    function automatic logic [6:0] hex_decode(input logic [3:0] nibble);
        logic [6:0] segs;
        case (nibble)
            4'h0: segs = 7'h3F;
            4'h1: segs = 7'h06;
            4'h2: segs = 7'h5B;
            4'h3: segs = 7'h4F;
            4'h4: segs = 7'h66;
            4'h5: segs = 7'h6D;
            4'h6: segs = 7'h7D;
            4'h7: segs = 7'h07;
            4'h8: segs = 7'h7F;
            4'h9: segs = 7'h6F;
            4'hA: segs = 7'h77;
            4'hB: segs = 7'h7C;
            4'hC: segs = 7'h39;
            4'hD: segs = 7'h5E;
            4'hE: segs = 7'h79;
            default: segs = 7'h71;
        endcase
        return segs;
    endfunction

    always_comb begin
        state_d       = state_q;
        ring_d        = ring_q;
        cnt_d         = cnt_q;
        snap_digits_d = snap_digits_q;
        snap_dp_d     = snap_dp_q;
        frame_end_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    snap_digits_d = digits_i;
                    snap_dp_d     = dp_i;
                    ring_d        = RingFirst;
                    cnt_d         = '0;
                    state_d       = BLANK;
                end
            end
            BLANK: begin
                if (cnt_q == BlankLast) begin
                    cnt_d   = '0;
                    state_d = ON;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            ON: begin
                if (cnt_q == OnLast) begin
                    cnt_d = '0;
                    // Enable is only honoured at digit boundaries so a digit is never cut short.
                    if (!en_i) begin
                        ring_d  = '0;
                        state_d = IDLE;
                    end else if (ring_q[num_digits_p-1]) begin
                        snap_digits_d = digits_i;
                        snap_dp_d     = dp_i;
                        ring_d        = RingFirst;
                        state_d       = BLANK;
                    end else begin
                        ring_d  = {ring_q[num_digits_p-2:0], ring_q[num_digits_p-1]};
                        state_d = BLANK;
                    end
                    frame_end_d = ring_q[num_digits_p-1];
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                ring_d  = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        lit_nibble = 4'h0;
        lit_dp     = 1'b0;
        for (int k = 0; k < num_digits_p; k++) begin
            if (ring_q[k]) begin
                lit_nibble = snap_digits_q[4*k +: 4];
                lit_dp     = snap_dp_q[k];
            end
        end
    end

    // Pins follow the current state one cycle later; nothing drives them combinationally.
    always_comb begin
        dig_sel_d = '0;
        seg_d     = '0;
        dp_d      = 1'b0;
        busy_d    = (state_q != IDLE);
        if (state_q == ON) begin
            dig_sel_d = ring_q;
            seg_d     = hex_decode(lit_nibble);
            dp_d      = lit_dp;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            ring_q        <= '0;
            cnt_q         <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            frame_end_q   <= 1'b0;
            dig_sel_q     <= '0;
            seg_q         <= '0;
            dp_q          <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ring_q        <= ring_d;
            cnt_q         <= cnt_d;
            snap_digits_q <= snap_digits_d;
            snap_dp_q     <= snap_dp_d;
            frame_end_q   <= frame_end_d;
            dig_sel_q     <= dig_sel_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_done_q  <= frame_end_q;
            busy_q        <= busy_d;
        end
    end

    assign dig_sel_o    = dig_sel_q;
    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign frame_done_o = frame_done_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed steps with random data, every cycle
// compared against a frame-timeline model of the display.
module tb_display_scan_ctrl;

    localparam int NumDigits = 4;
    localparam int OnCycles  = 4;
    localparam int BlankCyc  = 2;
    localparam int Period    = OnCycles + BlankCyc;
    localparam int FrameLen  = NumDigits * Period;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic [15:0] digits_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  dig_sel_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic        frame_done_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;
    int cycleNo = 0;
    int doneSeen = 0;
    int lastDone = -1;
    bit periodCheck = 1'b0;

    logic [6:0] segTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    display_scan_ctrl #(
        .num_digits_p  (NumDigits),
        .on_cycles_p   (OnCycles),
        .blank_cycles_p(BlankCyc)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .digits_i    (digits_i),
        .dp_i        (dp_i),
        .dig_sel_o   (dig_sel_o),
        .seg_o       (seg_o),
        .dp_o        (dp_o),
        .frame_done_o(frame_done_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycleNo++;

    // Reference: position within the frame timeline, pins lag that position by one clock.
    bit          mRunning = 1'b0;
    int          mT = 0;
    bit          mPending = 1'b0;
    logic [15:0] mSnap = '0;
    logic [3:0]  mSnapDp = '0;
    logic [3:0]  expDig = '0;
    logic [6:0]  expSeg = '0;
    logic        expDp = 1'b0;
    logic        expDone = 1'b0;
    logic        expBusy = 1'b0;
    int          dIdx;
    int          ph;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mRunning = 1'b0;
            mT = 0;
            mPending = 1'b0;
            mSnap = '0;
            mSnapDp = '0;
            expDig = '0;
            expSeg = '0;
            expDp = 1'b0;
            expDone = 1'b0;
            expBusy = 1'b0;
        end else begin
            dIdx = mT / Period;
            ph = mT % Period;
            expBusy = mRunning;
            expDone = mPending;
            mPending = 1'b0;
            expDig = '0;
            expSeg = '0;
            expDp = 1'b0;
            if (mRunning && ph >= BlankCyc) begin
                expDig = 4'(1 << dIdx);
                expSeg = segTable[mSnap[4*dIdx +: 4]];
                expDp = mSnapDp[dIdx];
            end
            if (!mRunning) begin
                if (en_i) begin
                    mRunning = 1'b1;
                    mT = 0;
                    mSnap = digits_i;
                    mSnapDp = dp_i;
                end
            end else if (ph == Period - 1) begin
                if (dIdx == NumDigits - 1) mPending = 1'b1;
                if (!en_i) begin
                    mRunning = 1'b0;
                    mT = 0;
                end else if (dIdx == NumDigits - 1) begin
                    mT = 0;
                    mSnap = digits_i;
                    mSnapDp = dp_i;
                end else begin
                    mT++;
                end
            end else begin
                mT++;
            end
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".dig_sel"}, 32'(dig_sel_o), 32'(expDig));
        checkValue({tag, ".seg"}, 32'(seg_o), 32'(expSeg));
        checkValue({tag, ".dp"}, 32'(dp_o), 32'(expDp));
        checkValue({tag, ".frame_done"}, 32'(frame_done_o), 32'(expDone));
        checkValue({tag, ".busy"}, 32'(busy_o), 32'(expBusy));
        checkValue({tag, ".onehot0"}, 32'($onehot0(dig_sel_o)), 32'd1);
        checkValue({tag, ".dark_when_off"}, (dig_sel_o == 4'b0) ? 32'({seg_o, dp_o}) : 32'd0, 32'd0);
    endtask

    task automatic applyStimulus(input logic en, input logic [15:0] digits, input logic [3:0] dp);
        en_i = en;
        digits_i = digits;
        dp_i = dp;
    endtask

    task automatic stepCycle(input string tag);
        @(negedge clk_i);
        checkOutput(tag);
        if (frame_done_o === 1'b1) begin
            doneSeen++;
            if (periodCheck && lastDone >= 0) checkValue("frame_period", 32'(cycleNo - lastDone), 32'(FrameLen));
            lastDone = cycleNo;
        end
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) stepCycle(tag);
    endtask

    task automatic waitDig(input logic [3:0] target, input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            stepCycle(tag);
            if (dig_sel_o === target) found = 1'b1;
        end
        checkValue({tag, ".reached"}, 32'(found), 32'd1);
    endtask

    task automatic waitDone(input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            stepCycle(tag);
            if (frame_done_o === 1'b1) found = 1'b1;
        end
        checkValue({tag, ".frame_done_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        logic [15:0] sweep [4];
        int doneBefore;
        bit found;
        sweep[0] = 16'h3210;
        sweep[1] = 16'h7654;
        sweep[2] = 16'hBA98;
        sweep[3] = 16'hFEDC;

        // Reset held with enable high: all pins stay dark.
        applyStimulus(1'b1, 16'h1234, 4'b0010);
        runCycles(5, "reset");

        // Release and time the first lit digit relative to the sampling edge.
        rst_ni = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            stepCycle("startup");
            if (dig_sel_o !== 4'b0) begin
                found = 1'b1;
                checkValue("first_digsel_edge", 32'(k), 32'd3);
                checkValue("first_digsel_value", 32'(dig_sel_o), 32'h1);
            end
        end
        checkValue("first_digsel_seen", 32'(found), 32'd1);

        // Basic frame 1234 followed by a repeat, with frame period tracking.
        periodCheck = 1'b1;
        runCycles(30, "basic");

        // Snapshot: inputs change during digit 1, frame finishes unchanged.
        waitDig(4'b0010, "snap_wait");
        applyStimulus(1'b1, 16'hFFFF, 4'($urandom));
        runCycles(2 * FrameLen, "snapshot");

        // Random inputs churning every cycle must never tear a frame.
        for (int i = 0; i < 3 * FrameLen; i++) begin
            applyStimulus(1'b1, 16'($urandom), 4'($urandom));
            stepCycle("churn");
        end

        // Disable during digit 2: it completes, then idle without frame_done.
        waitDig(4'b0100, "dis_wait");
        applyStimulus(1'b0, 16'($urandom), 4'($urandom));
        doneBefore = doneSeen;
        runCycles(12, "disable");
        checkValue("disable_busy", 32'(busy_o), 32'd0);
        checkValue("disable_no_done", 32'(doneSeen - doneBefore), 32'd0);

        // Decode sweep across all 16 nibble values.
        lastDone = -1;
        applyStimulus(1'b1, sweep[0], 4'($urandom));
        stepCycle("sweep_start");
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b1, sweep[i], 4'($urandom));
            waitDone("sweep");
        end
        waitDone("sweep_last");

        // Ten continuous frames of random content.
        doneBefore = doneSeen;
        for (int f = 0; f < 10; f++) begin
            applyStimulus(1'b1, 16'($urandom), 4'($urandom));
            waitDone("continuous");
        end
        checkValue("ten_frames", 32'(doneSeen - doneBefore), 32'd10);

        // Asynchronous reset while a digit is lit.
        waitDig(4'b0100, "rst_wait");
        #2;
        rst_ni = 1'b0;
        #1;
        checkValue("async_rst.dig_sel", 32'(dig_sel_o), 32'd0);
        checkValue("async_rst.seg", 32'(seg_o), 32'd0);
        checkValue("async_rst.dp", 32'(dp_o), 32'd0);
        checkValue("async_rst.busy", 32'(busy_o), 32'd0);
        checkValue("async_rst.frame_done", 32'(frame_done_o), 32'd0);
        periodCheck = 1'b0;
        applyStimulus(1'b0, 16'($urandom), 4'($urandom));
        @(negedge clk_i);
        rst_ni = 1'b1;
        runCycles(6, "post_reset_idle");
        checkValue("post_reset_busy", 32'(busy_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
